// File: rtl/compare_sched_pkg.sv
// Shared constants, payload types and helpers for the recFN compare scheduler.
package compare_sched_pkg;

    localparam int unsigned EXP_W        = 12;
    localparam int unsigned SIG_W        = 52;
    localparam int unsigned REC_W        = 1 + EXP_W + SIG_W;
    localparam int unsigned FLAG_W       = 5;
    localparam int unsigned FLAG_INVALID = 4;

    // A recoded value is NaN when the top three exponent bits are all set.
    function automatic logic is_nan_rec(input logic [REC_W-1:0] x);
        return &x[REC_W-2 -: 3];
    endfunction

    typedef struct packed {
        logic [REC_W-1:0] a;
        logic [REC_W-1:0] b;
        logic             signaling;
    } s1_t;

    typedef struct packed {
        logic              lt;
        logic              eq;
        logic              gt;
        logic              unordered;
        logic [FLAG_W-1:0] flags;
    } s2_t;

endpackage

// File: rtl/compare_rec_fn_scheduler_if.sv
// Request/response bundle between requesters and the shared comparator.
interface compare_rec_fn_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned REC_W   = 65
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*REC_W-1:0] req_a;
    logic [NUM_REQ*REC_W-1:0] req_b;
    logic [NUM_REQ-1:0]       req_signaling;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic                     resp_lt;
    logic                     resp_eq;
    logic                     resp_gt;
    logic                     resp_unordered;
    logic [4:0]               resp_flags;
    logic [4:0]               fflags_sticky;
    logic                     fflags_clear;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_signaling, resp_ready, fflags_clear,
        input  req_ready, resp_valid, resp_id, resp_lt, resp_eq, resp_gt, resp_unordered,
        input  resp_flags, fflags_sticky, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signaling, resp_ready, fflags_clear,
        output req_ready, resp_valid, resp_id, resp_lt, resp_eq, resp_gt, resp_unordered,
        output resp_flags, fflags_sticky, busy
    );

endinterface

// File: rtl/CompareRecFN.sv
// Combinational compare of two recoded floats (lt/eq/gt/unordered + invalid flag).
module CompareRecFN
    import compare_sched_pkg::*;
#(
    parameter int expWidth = 11,
    parameter int sigWidth = 53
) (
    input  logic [expWidth+sigWidth:0] a,
    input  logic [expWidth+sigWidth:0] b,
    input  logic                       signaling,
    output logic                       lt,
    output logic                       eq,
    output logic                       gt,
    output logic                       unordered,
    output logic [FLAG_W-1:0]          exceptionFlags
);

    localparam int EW = expWidth + 1;
    localparam int FW = sigWidth - 1;

    logic          sign_a, sign_b, zero_a, zero_b, inf_a, inf_b;
    logic          nan_a, nan_b, snan_a, snan_b;
    logic [EW-1:0] exp_a, exp_b;
    logic [FW:0]   sig_a, sig_b;
    logic          ordered, both_zero, both_inf, lt_mags, eq_mags, ord_lt, ord_eq, invalid;

    always_comb begin
        sign_a    = a[expWidth+sigWidth];
        sign_b    = b[expWidth+sigWidth];
        exp_a     = a[FW +: EW];
        exp_b     = b[FW +: EW];
        zero_a    = (exp_a[EW-1 -: 3] == 3'b000);
        zero_b    = (exp_b[EW-1 -: 3] == 3'b000);
        inf_a     = (exp_a[EW-1 -: 3] == 3'b110);
        inf_b     = (exp_b[EW-1 -: 3] == 3'b110);
        nan_a     = is_nan_rec(a);
        nan_b     = is_nan_rec(b);
        snan_a    = nan_a && !a[FW-1];
        snan_b    = nan_b && !b[FW-1];
        sig_a     = {!zero_a, a[FW-1:0]};
        sig_b     = {!zero_b, b[FW-1:0]};
        ordered   = !nan_a && !nan_b;
        both_zero = zero_a && zero_b;
        both_inf  = inf_a && inf_b;
        lt_mags   = (exp_a < exp_b) || ((exp_a == exp_b) && (sig_a < sig_b));
        eq_mags   = (exp_a == exp_b) && (sig_a == sig_b);
        ord_lt    = !both_zero && ((sign_a && !sign_b) ||
                    (!both_inf && ((sign_a && !lt_mags && !eq_mags) || (!sign_b && lt_mags))));
        ord_eq    = both_zero || ((sign_a == sign_b) && (both_inf || eq_mags));
        invalid   = snan_a || snan_b || (signaling && !ordered);

        lt        = ordered && ord_lt;
        eq        = ordered && ord_eq;
        gt        = ordered && !ord_lt && !ord_eq;
        unordered = !ordered;
        exceptionFlags               = '0;
        exceptionFlags[FLAG_INVALID] = invalid;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; priority rotates past the last accepted requester.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o
);

    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        idx        = '0;
        found      = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = idx;
            end
        end
    end

    assign last_d = accept_i ? grant_id_o : last_q;

    // Reset to the highest index so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/compare_rec_fn_scheduler.sv
// Shares one recFN comparator among NUM_REQ requesters through a two-stage
// (operand, result) pipeline with full backpressure and sticky exception flags.
module compare_rec_fn_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned REC_W   = 65
) (
    input logic                       clock,
    input logic                       reset,
    compare_rec_fn_scheduler_if.slave bus
);
    import compare_sched_pkg::*;

    logic [NUM_REQ-1:0] grant, ready;
    logic [ID_W-1:0]    grant_id;
    logic               s1_adv, s2_adv, accept;
    logic               ready_en_q;
    logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    s1_t                s1_q, s1_d;
    s2_t                s2_q, s2_d, cmp;
    logic [FLAG_W-1:0]  sticky_q, sticky_d, cmp_flags;
    logic               cmp_lt, cmp_eq, cmp_gt, cmp_un, resp_fire;

    assign s2_adv    = !s2_valid_q || bus.resp_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    // ready_en_q keeps every req_ready low while reset is held.
    assign ready     = (ready_en_q && s1_adv) ? grant : '0;
    assign accept    = |(bus.req_valid & ready);
    assign resp_fire = s2_valid_q && bus.resp_ready;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .clk_i     (clock),
        .rst_ni    (reset),
        .req_i     (bus.req_valid),
        .accept_i  (accept),
        .grant_o   (grant),
        .grant_id_o(grant_id)
    );

    CompareRecFN #(
        .expWidth(11),
        .sigWidth(53)
    ) u_cmp (
        .a             (s1_q.a),
        .b             (s1_q.b),
        .signaling     (s1_q.signaling),
        .lt            (cmp_lt),
        .eq            (cmp_eq),
        .gt            (cmp_gt),
        .unordered     (cmp_un),
        .exceptionFlags(cmp_flags)
    );

    always_comb begin
        cmp        = '{lt: cmp_lt, eq: cmp_eq, gt: cmp_gt, unordered: cmp_un, flags: cmp_flags};
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        s2_id_d    = s2_id_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d.a         = bus.req_a[grant_id*REC_W +: REC_W];
                s1_d.b         = bus.req_b[grant_id*REC_W +: REC_W];
                s1_d.signaling = bus.req_signaling[grant_id];
                s1_id_d        = grant_id;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d    = cmp;
                s2_id_d = s1_id_q;
            end
        end
        // A same-cycle clear must not drop flags of the response completing now.
        sticky_d = (bus.fflags_clear ? '0 : sticky_q) | (resp_fire ? s2_q.flags : '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s1_id_q    <= '0;
            s2_id_q    <= '0;
            sticky_q   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s1_id_q    <= s1_id_d;
            s2_id_q    <= s2_id_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.req_ready      = ready;
    assign bus.resp_valid     = s2_valid_q;
    assign bus.resp_id        = s2_id_q;
    assign bus.resp_lt        = s2_q.lt;
    assign bus.resp_eq        = s2_q.eq;
    assign bus.resp_gt        = s2_q.gt;
    assign bus.resp_unordered = s2_q.unordered;
    assign bus.resp_flags     = s2_q.flags;
    assign bus.fflags_sticky  = sticky_q;
    assign bus.busy           = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_compare_rec_fn_scheduler.sv
// Self-checking bench: vector table, response scoreboard and multi-cycle corner sequences.
module tb_compare_rec_fn_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned REC_W   = 65;

    localparam logic [REC_W-1:0] ONE     = 65'h0_8000_0000_0000_0000;
    localparam logic [REC_W-1:0] TWO     = 65'h0_8010_0000_0000_0000;
    localparam logic [REC_W-1:0] THREE   = 65'h0_8018_0000_0000_0000;
    localparam logic [REC_W-1:0] NEG_ONE = 65'h1_8000_0000_0000_0000;
    localparam logic [REC_W-1:0] NEG_TWO = 65'h1_8010_0000_0000_0000;
    localparam logic [REC_W-1:0] PZERO   = 65'h0_0000_0000_0000_0000;
    localparam logic [REC_W-1:0] NZERO   = 65'h1_0000_0000_0000_0000;
    localparam logic [REC_W-1:0] PINF    = 65'h0_C000_0000_0000_0000;
    localparam logic [REC_W-1:0] SNAN    = 65'h0_E000_0000_0000_0001;
    localparam logic [REC_W-1:0] QNAN    = 65'h0_E008_0000_0000_0000;

    typedef struct packed {
        logic       lt;
        logic       eq;
        logic       gt;
        logic       un;
        logic [4:0] flags;
    } res_t;

    typedef struct packed {
        logic [REC_W-1:0] a;
        logic [REC_W-1:0] b;
        logic             sig;
        res_t             r;
    } vec_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        res_t            r;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    compare_rec_fn_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .REC_W(REC_W)) bus ();

    compare_rec_fn_scheduler #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .REC_W  (REC_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    vec_t  vecs[12];
    exp_t  exp_cur[NUM_REQ];
    exp_t  sb[$];
    exp_t  mon_e;
    int    acc_log[$];
    int    acc_cyc[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [REC_W-1:0] a, input logic [REC_W-1:0] b,
                                input logic sig, input logic [8:0] r);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.sig = sig;
        v.r   = r;
        return v;
    endfunction

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    mon_e    = exp_cur[i];
                    mon_e.id = ID_W'(i);
                    sb.push_back(mon_e);
                    acc_log.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_id_lt_eq_gt_un_flags",
                          {bus.resp_id, bus.resp_lt, bus.resp_eq, bus.resp_gt,
                           bus.resp_unordered, bus.resp_flags}, mon_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input vec_t v);
        exp_cur[i].id                   = ID_W'(i);
        exp_cur[i].r                    = v.r;
        bus.req_a[i*REC_W +: REC_W]     = v.a;
        bus.req_b[i*REC_W +: REC_W]     = v.b;
        bus.req_signaling[i]            = v.sig;
        bus.req_valid[i]                = 1'b1;
    endtask

    task automatic send(input int i, input vec_t v);
        int n = 0;
        set_req(i, v);
        do begin
            @(negedge clock);
            n++;
        end while (!bus.req_ready[i] && n < 50);
        if (!bus.req_ready[i]) check("send_timeout", 64'd0, 64'd1);
        step();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [10:0] snap;
        int          n;
        bus.req_valid     = '0;
        bus.req_a         = '0;
        bus.req_b         = '0;
        bus.req_signaling = '0;
        bus.resp_ready    = 1'b1;
        bus.fflags_clear  = 1'b0;

        //               a        b      sig  lt eq gt un flags
        vecs[0]  = mk(ONE,     TWO,     1'b0, 9'b1000_00000);
        vecs[1]  = mk(TWO,     ONE,     1'b0, 9'b0010_00000);
        vecs[2]  = mk(PZERO,   NZERO,   1'b0, 9'b0100_00000);
        vecs[3]  = mk(ONE,     ONE,     1'b1, 9'b0100_00000);
        vecs[4]  = mk(NEG_ONE, ONE,     1'b1, 9'b1000_00000);
        vecs[5]  = mk(PINF,    TWO,     1'b0, 9'b0010_00000);
        vecs[6]  = mk(NEG_TWO, NEG_ONE, 1'b1, 9'b1000_00000);
        vecs[7]  = mk(SNAN,    ONE,     1'b0, 9'b0001_10000);
        vecs[8]  = mk(QNAN,    ONE,     1'b1, 9'b0001_10000);
        vecs[9]  = mk(QNAN,    ONE,     1'b0, 9'b0001_00000);
        vecs[10] = mk(ONE,     QNAN,    1'b0, 9'b0001_00000);
        vecs[11] = mk(THREE,   TWO,     1'b0, 9'b0010_00000);

        // Reset state, with a request pending to show req_ready stays low.
        #1 reset = 1'b0;
        bus.req_valid[0] = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sticky", bus.fflags_sticky, 0);
        check("rst_resp_data", {bus.resp_id, bus.resp_lt, bus.resp_eq, bus.resp_gt,
                                bus.resp_unordered, bus.resp_flags}, 0);
        bus.req_valid[0] = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Latency: accepted at edge t, resp_valid high after edge t+1.
        set_req(0, vecs[0]);
        @(negedge clock);
        check("lat_req_ready", bus.req_ready[0], 1);
        step();
        bus.req_valid[0] = 1'b0;
        @(negedge clock);
        check("lat_t_resp_valid", bus.resp_valid, 0);
        check("lat_t_busy", bus.busy, 1);
        @(negedge clock);
        check("lat_t1_resp_valid", bus.resp_valid, 1);
        drain();

        // Vector table on requester 0.
        for (int k = 0; k < 7; k++) send(0, vecs[k]);
        drain();
        check("sticky_no_invalid", bus.fflags_sticky, 0);
        for (int k = 7; k < 12; k++) send(0, vecs[k]);
        drain();
        check("sticky_after_invalid", bus.fflags_sticky, 5'b10000);

        // Clear with no response in flight.
        bus.fflags_clear = 1'b1;
        step();
        bus.fflags_clear = 1'b0;
        @(negedge clock);
        check("sticky_clear", bus.fflags_sticky, 0);

        // Round robin: last grant was requester 0, so order is 1,2,3,0,...
        acc_log.delete();
        acc_cyc.delete();
        step();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, vecs[i]);
        n = 0;
        while (acc_log.size() < 12 && n < 60) begin
            @(negedge clock);
            n++;
        end
        step();
        bus.req_valid = '0;
        if (acc_log.size() >= 12) begin
            for (int j = 0; j < 12; j++) check("rr_order", acc_log[j], (j + 1) % NUM_REQ);
            check("rr_one_per_cycle", acc_cyc[11] - acc_cyc[0], 11);
        end else begin
            check("rr_accept_count", acc_log.size(), 12);
        end
        drain();

        // Backpressure: exactly two accepted, then everything holds.
        bus.resp_ready = 1'b0;
        acc_log.delete();
        set_req(0, vecs[1]);
        set_req(1, vecs[5]);
        repeat (5) @(negedge clock);
        check("bp_accepts", acc_log.size(), 2);
        check("bp_req_ready", bus.req_ready, 0);
        check("bp_resp_valid", bus.resp_valid, 1);
        snap = {bus.resp_id, bus.resp_lt, bus.resp_eq, bus.resp_gt,
                bus.resp_unordered, bus.resp_flags};
        repeat (3) @(negedge clock);
        check("bp_resp_stable", {bus.resp_id, bus.resp_lt, bus.resp_eq, bus.resp_gt,
                                 bus.resp_unordered, bus.resp_flags}, snap);
        check("bp_accepts_hold", acc_log.size(), 2);
        step();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        drain();

        // Clear in the same cycle as an invalid response handshake.
        bus.resp_ready = 1'b0;
        send(2, vecs[7]);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("clr_resp_valid", bus.resp_valid, 1);
        check("clr_sticky_before", bus.fflags_sticky, 0);
        step();
        bus.resp_ready   = 1'b1;
        bus.fflags_clear = 1'b1;
        step();
        bus.fflags_clear = 1'b0;
        @(negedge clock);
        check("clr_sticky_survives", bus.fflags_sticky, 5'b10000);
        drain();

        // Reset with S1 and S2 full.
        bus.resp_ready = 1'b0;
        set_req(0, vecs[0]);
        set_req(1, vecs[2]);
        repeat (4) @(negedge clock);
        check("mid_busy", bus.busy, 1);
        step();
        reset = 1'b0;
        sb.delete();
        set_req(2, vecs[3]);
        set_req(3, vecs[4]);
        @(negedge clock);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sticky", bus.fflags_sticky, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        step();
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        acc_log.delete();
        n = 0;
        while (acc_log.size() < 1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (acc_log.size() >= 1) check("mid_first_grant", acc_log[0], 0);
        else check("mid_no_grant", 64'd0, 64'd1);
        step();
        bus.req_valid = '0;
        drain();
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/compare_rec_fn_scheduler.md
# compare_rec_fn_scheduler

Shares one double-precision recoded-float comparator (`CompareRecFN`, 65-bit recFN operands) among `NUM_REQ` requesters, e.g. FPU issue ports, a sort engine and a min/max unit. Requesters are arbitrated round-robin through valid/ready handshakes. Operands and results each pass through a pipeline register, with full backpressure. Exception flags from completed responses are accumulated into a sticky register that software can clear.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: requester-index width, equal to clog2(`NUM_REQ`).
- `REC_W`, default 65: recoded operand width (1 + 12 + 52).

Ports:
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester request valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept.
- `req_a`, in, `NUM_REQ`*`REC_W`: operand A; requester i occupies slice [i*`REC_W` +: `REC_W`].
- `req_b`, in, `NUM_REQ`*`REC_W`: operand B, same slicing as `req_a`.
- `req_signaling`, in, `NUM_REQ`: 1 selects a signaling compare (lt/le), 0 a quiet compare (eq).
- `resp_valid`, out, 1: response valid.
- `resp_ready`, in, 1: response accept.
- `resp_id`, out, `ID_W`: index of the requester that issued the request.
- `resp_lt`, out, 1: A < B.
- `resp_eq`, out, 1: A == B.
- `resp_gt`, out, 1: ordered, not lt and not eq.
- `resp_unordered`, out, 1: A or B is NaN.
- `resp_flags`, out, 5: exception flags, {invalid, 4'b0}.
- `fflags_sticky`, out, 5: accumulated exception flags.
- `fflags_clear`, in, 1: synchronous clear of `fflags_sticky`.
- `busy`, out, 1: `s1_valid` | `s2_valid`.

## Operation
- Pipeline stages:
  - S1 holds the granted operands, the signaling bit and the id.
  - The comparator is combinational between S1 and S2.
  - S2 holds lt, eq, gt, unordered, flags and id.
- Stall chain:
  - `s2_adv = !s2_valid | resp_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
- Arbiter:
  - The grant is one-hot over `req_valid`. Priority starts at `last_grant`+1 modulo `NUM_REQ`.
  - `req_ready[i] = grant[i] & s1_adv`. The grant is combinational and independent of `req_ready`.
  - `last_grant` updates only on a completed handshake (`req_valid[i]` & `req_ready[i]`).
- Requesters hold valid and operands stable until ready. Dropping valid before ready is legal; that request is simply not taken.
- `resp_unordered` is 1 when recoded exp[11:9] == 3'b111 for either operand.
- When `resp_unordered` is 1, lt, eq and gt are all 0.
- `resp_*` are driven directly from S2 registers; there is no combinational path from inputs to the response.
- Sticky flags: `next = (fflags_clear ? 0 : sticky) | (resp_valid & resp_ready ? resp_flags : 0)`. When clear and a response handshake occur in the same cycle, the new flags survive.
- Reset values:
  - `s1_valid`, `s2_valid`, `resp_valid`, `busy` = 0.
  - `resp_*` data = 0.
  - `fflags_sticky` = 0.
  - `last_grant` = `NUM_REQ`-1, so requester 0 wins first.
  - `req_ready` = 0 while `reset` is asserted.
- Reset mid-operation discards in-flight entries and produces no response.

## Timing
- Latency: a request accepted at edge t gives `resp_valid` high after edge t+1, so the response is visible in cycle t+1 to t+2.
- Throughput is one compare per cycle while `resp_ready` is held high.
- Backpressure: with `resp_ready` low, S2 and S1 fill. After that, `req_ready` is all zeros and S1/S2 contents hold unchanged.
- Draining: the cycle `resp_ready` rises, S2 takes S1, S1 takes a new grant, and all three happen at the same edge.
- `resp_valid` stays high and response data stays stable until the handshake completes.

## Structure
- Package `compare_sched_pkg`:
  - `REC_W`, `EXP_W`=12, `SIG_W`=52.
  - Flag bit positions: `FLAG_INVALID`=4.
  - Function `is_nan_rec(x)`.
  - Struct types for the S1 and S2 payloads.
- Instantiates the existing `CompareRecFN` combinationally between S1 and S2.
- One new sub-module, `rr_arbiter` (parameterised by `NUM_REQ`): one-hot grant plus `last_grant` register, advanced by an `accept` input.

## Test plan
- Requester 0 sends A=65'h0_8000_0000_0000_0000 (1.0), B=65'h0_8010_0000_0000_0000 (2.0) -> two cycles later `resp_id`=0, `lt`=1, `eq`=0, `gt`=0, flags=0.
- All 4 requesters assert valid continuously with `resp_ready`=1 -> grants go 0,1,2,3,0,… with one response per cycle and `resp_id` in the same order.
- A=+0 (65'h0), B=−0 (65'h1_0000_0000_0000_0000) -> `eq`=1, `lt`=0.
- A=sNaN 65'h0_E000_0000_0000_0001, `req_signaling`=0 -> `unordered`=1, flags=5'b10000, `fflags_sticky`=5'b10000 after the handshake.
- A=qNaN 65'h0_E008_0000_0000_0000 with `req_signaling`=1 -> flags 5'b10000.
- A=qNaN 65'h0_E008_0000_0000_0000 with `req_signaling`=0 -> flags 0.
- Hold `resp_ready`=0 for 5 cycles with requests pending -> exactly 2 accepted, then `req_ready`=0 and `resp_*` stable. Then release `resp_ready` -> both responses arrive in order.
- Pulse `fflags_clear` in the same cycle as an invalid response handshake -> sticky = 5'b10000.
- Assert `reset` low while S1 and S2 are full -> all valids 0 and `fflags_sticky`=0; after release, requester 0 is granted first.
